// File: rtl/ai_pkg.sv
// Shared definitions for the AI engine arbiter: FSM encoding, AI opcode
// constants, requester ids and the timeout counter width.
package ai_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // AI opcodes understood by the shared engine
  localparam logic [2:0] OP_DOT     = 3'b000;
  localparam logic [2:0] OP_MATMUL  = 3'b001;
  localparam logic [2:0] OP_RELU    = 3'b010;
  localparam logic [2:0] OP_SIGMOID = 3'b011;
  localparam logic [2:0] OP_STEP    = 3'b100;

  // Requester ids; the id equals the bit position in req_valid/req_ready
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_AUX  = 1'b1;

  // Wide enough for the largest legal TIMEOUT_CYCLES (65535)
  localparam int TIMER_W = 16;

  // Converts a one-hot two-requester grant into a requester id
  function automatic logic grant_to_id(input logic [1:0] grant);
    return grant[1] ? REQ_AUX : REQ_CORE;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. A lone requester always wins; on a tie
// the requester that was not granted last wins.
module rr_arbiter2
  import ai_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant selection from the valid vector and round-robin pointer
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == REQ_AUX) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ai_engine_arbiter.sv
// Arbitrates two requesters (core EX stage and auxiliary port) onto one
// shared multi-cycle AI engine, waits for completion or timeout and returns
// a single response per accepted request.
//
// Handshake rule for every valid/ready pair in this block: a transfer happens
// on a rising clk edge where both valid and ready are 1; valid never waits on
// ready, and the payload is held stable while valid is 1 and ready is 0.
module ai_engine_arbiter
  import ai_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DATA_W         = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [5:0]          req_opcode,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [9:0]          req_tag,
  output logic                eng_start,
  output logic [2:0]          eng_opcode,
  output logic [DATA_W-1:0]   eng_a,
  output logic [DATA_W-1:0]   eng_b,
  input  logic                eng_done,
  input  logic [DATA_W-1:0]   eng_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [4:0]          rsp_tag,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_error,
  output logic                busy,
  output logic [15:0]         op_count,
  output logic [1:0]          dbg_state
);

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t               state;
  state_t               state_next;
  logic                 last_grant;
  logic [TIMER_W-1:0]   timer;
  logic [1:0]           grant;
  logic                 accept;
  logic                 timeout_hit;
  logic                 sel_id;
  logic [2:0]           sel_opcode;
  logic [DATA_W-1:0]    sel_a;
  logic [DATA_W-1:0]    sel_b;
  logic [4:0]           sel_tag;

  rr_arbiter2 u_rr (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign timeout_hit = (timer == TIMEOUT_LAST);
  assign dbg_state   = state;

  // Payload mux: pick the granted requester's opcode, operands and tag
  always_comb begin
    sel_id     = grant_to_id(grant);
    sel_opcode = req_opcode[2:0];
    sel_a      = req_a[DATA_W-1:0];
    sel_b      = req_b[DATA_W-1:0];
    sel_tag    = req_tag[4:0];
    if (sel_id == REQ_AUX) begin
      sel_opcode = req_opcode[5:3];
      sel_a      = req_a[2*DATA_W-1:DATA_W];
      sel_b      = req_b[2*DATA_W-1:DATA_W];
      sel_tag    = req_tag[9:5];
    end
  end

  // Next-state and handshake/strobe outputs; all strobes forced low in reset
  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    eng_start  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state != IDLE);
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (|(req_valid & grant)) begin
          accept     = 1'b1;
          state_next = START;
        end
      end
      START: begin
        eng_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        // Completion takes priority over a timeout on the same cycle
        if (eng_done || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!reset) begin
      req_ready  = 2'b00;
      eng_start  = 1'b0;
      rsp_valid  = 1'b0;
      busy       = 1'b0;
      accept     = 1'b0;
      state_next = IDLE;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request capture: engine operands, response id/tag and round-robin pointer
  always_ff @(posedge clk) begin
    if (!reset) begin
      eng_opcode <= 3'b000;
      eng_a      <= '0;
      eng_b      <= '0;
      rsp_tag    <= 5'd0;
      rsp_id     <= REQ_CORE;
      last_grant <= REQ_AUX;
    end else if (accept) begin
      eng_opcode <= sel_opcode;
      eng_a      <= sel_a;
      eng_b      <= sel_b;
      rsp_tag    <= sel_tag;
      rsp_id     <= sel_id;
      last_grant <= sel_id;
    end
  end

  // WAIT timer plus result/error capture; eng_done only matters in WAIT
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer     <= '0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        START: timer <= '0;
        WAIT: begin
          if (eng_done) begin
            rsp_data  <= eng_result;
            rsp_error <= 1'b0;
          end else if (timeout_hit) begin
            rsp_data  <= '0;
            rsp_error <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Completed-response counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_count <= 16'd0;
    end else if (state == RESP && rsp_ready) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ai_engine_arbiter.sv
// Bench for ai_engine_arbiter: table of transactions plus hand sequences for
// reset abort, stray eng_done and done/timeout coincidence on a short-timeout
// instance.
module tb_ai_engine_arbiter;
  import ai_pkg::*;

  localparam int DW      = 32;
  localparam int T_MAIN  = 8;
  localparam int T_SHORT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [5:0]      req_opcode;
  logic [2*DW-1:0] req_a;
  logic [2*DW-1:0] req_b;
  logic [9:0]      req_tag;
  logic            eng_start;
  logic [2:0]      eng_opcode;
  logic [DW-1:0]   eng_a, eng_b;
  logic            eng_done;
  logic [DW-1:0]   eng_result;
  logic            rsp_valid, rsp_ready, rsp_id, rsp_error, busy;
  logic [4:0]      rsp_tag;
  logic [DW-1:0]   rsp_data;
  logic [15:0]     op_count;
  logic [1:0]      dbg_state;

  logic            t4_reset;
  logic [1:0]      t4_req_valid, t4_req_ready;
  logic            t4_eng_start, t4_eng_done;
  logic [2:0]      t4_eng_opcode;
  logic [DW-1:0]   t4_eng_a, t4_eng_b, t4_eng_result, t4_rsp_data;
  logic            t4_rsp_valid, t4_rsp_ready, t4_rsp_id, t4_rsp_error, t4_busy;
  logic [4:0]      t4_rsp_tag;
  logic [15:0]     t4_op_count;
  logic [1:0]      t4_dbg_state;

  ai_engine_arbiter #(.TIMEOUT_CYCLES(T_MAIN), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .eng_start(eng_start), .eng_opcode(eng_opcode), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_result(eng_result), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .busy(busy), .op_count(op_count), .dbg_state(dbg_state)
  );

  ai_engine_arbiter #(.TIMEOUT_CYCLES(T_SHORT), .DATA_W(DW)) dut4 (
    .clk(clk), .reset(t4_reset), .req_valid(t4_req_valid), .req_ready(t4_req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .eng_start(t4_eng_start), .eng_opcode(t4_eng_opcode), .eng_a(t4_eng_a),
    .eng_b(t4_eng_b), .eng_done(t4_eng_done), .eng_result(t4_eng_result),
    .rsp_valid(t4_rsp_valid), .rsp_ready(t4_rsp_ready), .rsp_id(t4_rsp_id),
    .rsp_tag(t4_rsp_tag), .rsp_data(t4_rsp_data), .rsp_error(t4_rsp_error),
    .busy(t4_busy), .op_count(t4_op_count), .dbg_state(t4_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int exp_count = 0;
  logic [38:0] exp_q[$];   // {id, tag, data, error}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          keep;
    logic [1:0]  valid;
    logic [2:0]  op0;
    logic [31:0] a0, b0;
    logic [4:0]  tag0;
    logic [2:0]  op1;
    logic [31:0] a1, b1;
    logic [4:0]  tag1;
    int          done_at;   // WAIT cycle carrying eng_done, 0 = never
    logic [31:0] result;
    int          hold;      // cycles rsp_ready stays low in RESP
    logic        exp_id;
    logic [4:0]  exp_tag;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(
    input bit rst, input bit keep, input logic [1:0] valid,
    input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0, input logic [4:0] tag0,
    input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1, input logic [4:0] tag1,
    input int done_at, input logic [31:0] result, input int hold,
    input logic exp_id, input logic [4:0] exp_tag, input logic [31:0] exp_data, input logic exp_err);
    vec_t v;
    v.rst = rst; v.keep = keep; v.valid = valid;
    v.op0 = op0; v.a0 = a0; v.b0 = b0; v.tag0 = tag0;
    v.op1 = op1; v.a1 = a1; v.b1 = b1; v.tag1 = tag1;
    v.done_at = done_at; v.result = result; v.hold = hold;
    v.exp_id = exp_id; v.exp_tag = exp_tag; v.exp_data = exp_data; v.exp_err = exp_err;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; req_valid = 2'b00; eng_done = 1'b0; rsp_ready = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", dbg_state, IDLE);
    check("rst_op_count", op_count, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_eng_opcode", eng_opcode, 0);
    check("rst_eng_a", eng_a, 0);
    check("rst_eng_b", eng_b, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_count = 0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [38:0] rec;
    int cnt;
    int limit;
    bit seen;
    if (v.rst) do_reset();
    @(negedge clk);
    req_valid  = v.valid;
    req_opcode = {v.op1, v.op0};
    req_a      = {v.a1, v.a0};
    req_b      = {v.b1, v.b0};
    req_tag    = {v.tag1, v.tag0};
    exp_q.push_back({v.exp_id, v.exp_tag, v.exp_data, v.exp_err});
    #1;
    check("grant", req_ready, v.exp_id ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    check("eng_start", eng_start, 1);
    check("eng_opcode", eng_opcode, v.exp_id ? v.op1 : v.op0);
    check("eng_a", eng_a, v.exp_id ? v.a1 : v.a0);
    check("eng_b", eng_b, v.exp_id ? v.b1 : v.b0);
    check("ready_low_start", req_ready, 0);
    if (!v.keep) req_valid = 2'b00;
    limit = ((v.done_at > 0) ? v.done_at : T_MAIN) + 4;
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      eng_done = 1'b0;
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      cnt++;
      if (cnt == 1) check("start_one_cycle", eng_start, 0);
      if (cnt == v.done_at) begin
        eng_done   = 1'b1;
        eng_result = v.result;
      end
    end
    check("rsp_arrive", seen, 1);
    check("wait_cycles", cnt, (v.done_at > 0) ? v.done_at : T_MAIN);
    rec = exp_q.pop_front();
    if (!seen) begin
      do_reset();
      return;
    end
    check("rsp_id", rsp_id, rec[38]);
    check("rsp_tag", rsp_tag, rec[37:33]);
    check("rsp_data", rsp_data, rec[32:1]);
    check("rsp_error", rsp_error, rec[0]);
    check("ready_low_resp", req_ready, 0);
    for (int h = 0; h < v.hold; h++) begin
      if (h == 1) begin
        eng_done   = 1'b1;          // stray completion outside WAIT
        eng_result = ~v.result;
      end
      @(posedge clk); #1;
      eng_done = 1'b0;
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, rec[32:1]);
      check("hold_tag", rsp_tag, rec[37:33]);
      check("hold_error", rsp_error, rec[0]);
      check("hold_ready_low", req_ready, 0);
      check("hold_count", op_count, exp_count);
    end
    rsp_ready = 1'b1;
    #1;
    check("no_accept_on_complete", req_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_count = (exp_count + 1) & 16'hFFFF;
    check("op_count", op_count, exp_count);
    check("rsp_drop", rsp_valid, 0);
    check("back_idle", dbg_state, IDLE);
    if (!v.keep) req_valid = 2'b00;
  endtask

  // Short-timeout instance: one transaction from requester 0
  task automatic t4_run(input int done_at, input logic [31:0] result,
                        input logic [31:0] exp_data, input logic exp_err, input int exp_ops);
    int cnt;
    bit seen;
    @(negedge clk);
    t4_req_valid = 2'b01;
    req_opcode = {OP_DOT, OP_MATMUL};
    req_a = {32'd0, 32'd21};
    req_b = {32'd0, 32'd2};
    req_tag = {5'd0, 5'd7};
    #1;
    check("t4_grant", t4_req_ready, 2'b01);
    @(posedge clk); #1;
    t4_req_valid = 2'b00;
    check("t4_eng_start", t4_eng_start, 1);
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < T_SHORT + 4; i++) begin
      @(posedge clk); #1;
      t4_eng_done = 1'b0;
      if (t4_rsp_valid) begin
        seen = 1'b1;
        break;
      end
      cnt++;
      if (cnt == done_at) begin
        t4_eng_done   = 1'b1;
        t4_eng_result = result;
      end
    end
    check("t4_rsp_arrive", seen, 1);
    check("t4_wait_cycles", cnt, (done_at > 0) ? done_at : T_SHORT);
    check("t4_rsp_data", t4_rsp_data, exp_data);
    check("t4_rsp_error", t4_rsp_error, exp_err);
    check("t4_rsp_tag", t4_rsp_tag, 5'd7);
    t4_rsp_ready = 1'b1;
    @(posedge clk); #1;
    t4_rsp_ready = 1'b0;
    check("t4_op_count", t4_op_count, exp_ops);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[9];

  initial begin
    reset = 1'b0; req_valid = 2'b00; req_opcode = '0; req_a = '0; req_b = '0;
    req_tag = '0; eng_done = 1'b0; eng_result = '0; rsp_ready = 1'b0;
    t4_reset = 1'b0; t4_req_valid = 2'b00; t4_eng_done = 1'b0;
    t4_eng_result = '0; t4_rsp_ready = 1'b0;

    vecs[0] = mk(1, 0, 2'b01, OP_MATMUL, 3, 4, 5, OP_DOT, 0, 0, 0, 2, 12, 0, 0, 5, 12, 0);
    vecs[1] = mk(1, 1, 2'b11, OP_DOT, 10, 11, 1, OP_SIGMOID, 20, 21, 2, 1, 100, 0, 0, 1, 100, 0);
    vecs[2] = mk(0, 1, 2'b11, OP_DOT, 10, 11, 1, OP_SIGMOID, 20, 21, 2, 3, 200, 0, 1, 2, 200, 0);
    vecs[3] = mk(0, 1, 2'b11, OP_DOT, 10, 11, 1, OP_SIGMOID, 20, 21, 2, 1, 300, 0, 0, 1, 300, 0);
    vecs[4] = mk(0, 0, 2'b11, OP_DOT, 10, 11, 1, OP_SIGMOID, 20, 21, 2, 2, 400, 0, 1, 2, 400, 0);
    vecs[5] = mk(0, 0, 2'b10, OP_DOT, 0, 0, 0, OP_STEP, 5, 6, 31, 0, 32'hFFFF, 0, 1, 31, 0, 1);
    vecs[6] = mk(0, 0, 2'b01, OP_RELU, 32'hFFFF_FFFF, 1, 0, OP_DOT, 0, 0, 0,
                 3, 32'hDEAD_BEEF, 5, 0, 0, 32'hDEAD_BEEF, 0);
    vecs[7] = mk(0, 0, 2'b11, OP_DOT, 1, 2, 3, OP_MATMUL, 8, 9, 9, 8, 32'h1234, 0, 1, 9, 32'h1234, 0);
    vecs[8] = mk(0, 0, 2'b11, OP_SIGMOID, 6, 7, 12, OP_STEP, 1, 1, 13, 7, 55, 1, 0, 12, 55, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    t4_reset = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // stray eng_done while IDLE changes nothing
    @(negedge clk);
    eng_done = 1'b1; eng_result = 32'h99;
    @(posedge clk); #1;
    eng_done = 1'b0;
    check("idle_done_state", dbg_state, IDLE);
    check("idle_done_data", rsp_data, 55);
    check("idle_done_count", op_count, exp_count);
    check("idle_done_busy", busy, 0);

    // reset in the middle of WAIT aborts silently; late eng_done ignored
    @(negedge clk);
    req_valid = 2'b01; req_opcode = {OP_DOT, OP_RELU};
    req_a = {32'd0, 32'd9}; req_b = {32'd0, 32'd8}; req_tag = {5'd0, 5'd3};
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("abort_in_wait", dbg_state, WAIT);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    check("abort_state", dbg_state, IDLE);
    check("abort_eng_a", eng_a, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_count = 0;
    @(posedge clk); #1;
    eng_done = 1'b1; eng_result = 32'd77;
    @(posedge clk); #1;
    eng_done = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("late_done_rsp", rsp_valid, 0);
      check("late_done_state", dbg_state, IDLE);
    end
    check("late_done_count", op_count, exp_count);
    check("late_done_data", rsp_data, 0);

    // short timeout: done on the last WAIT cycle wins, then a real timeout
    t4_run(T_SHORT, 32'hA5A5, 32'hA5A5, 1'b0, 1);
    t4_run(0, 32'h0, 32'h0, 1'b1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ai_engine_arbiter.md
AI_ENGINE_ARBITER -- requirements
Module: ai_engine_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, SHALL set the maximum number of WAIT cycles before an operation is aborted (legal 2..65535).
REQ-002 Parameter DATA_W, default 32, SHALL set the operand and result width.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; asserted when 0 and sampled on clk rising edge.
REQ-005 req_valid  input  2  per-requester request valid; bit 0 = core EX stage, bit 1 = auxiliary port.
REQ-006 req_ready  output  2  per-requester accept; a request transfers on the cycle valid&ready are both 1.
REQ-007 req_opcode  input  6  {req1, req0} 3-bit AI opcodes.
REQ-008 req_a / req_b  input  2*DATA_W each  {req1, req0} operands.
REQ-009 req_tag  input  10  {req1, req0} 5-bit destination-register tags.
REQ-010 eng_start  output  1  one-cycle start pulse to the shared multi-cycle AI engine.
REQ-011 eng_opcode / eng_a / eng_b  output  3 / DATA_W / DATA_W  operands held stable from eng_start until the operation ends.
REQ-012 eng_done  input  1  engine completion pulse; eng_result  input  DATA_W  valid when eng_done=1.
REQ-013 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-014 rsp_id  output  1, rsp_tag  output  5, rsp_data  output  DATA_W, rsp_error  output  1  response payload.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 op_count  output  16  count of completed responses, wraps 0xFFFF->0.

Function
REQ-017 FSM states SHALL be IDLE, START, WAIT, RESP.
REQ-018 IDLE: if any req_valid, the grant SHALL go to the only valid requester, or when both are valid, to the requester not granted last (round-robin pointer last_grant).
REQ-019 req_ready SHALL be 1 only for the granted requester, only in IDLE; it SHALL be 0 for both in all other states.
REQ-020 On transfer: latch opcode, operands, tag, and id; update last_grant; next state START.
REQ-021 START: eng_start=1 for exactly one cycle; WAIT timer cleared to 0; next state WAIT.
REQ-022 WAIT: on eng_done=1, capture eng_result into rsp_data, set rsp_error=0, go to RESP.
REQ-023 WAIT: otherwise increment timer; when timer reaches TIMEOUT_CYCLES-1 without done, go to RESP with rsp_data=0, rsp_error=1.
REQ-024 eng_done and timer expiry on the same cycle: done SHALL win (rsp_error=0).
REQ-025 eng_done outside WAIT SHALL be ignored and SHALL NOT alter any state.
REQ-026 RESP: rsp_valid=1 with stable payload until rsp_ready=1; on that cycle increment op_count, go to IDLE.
REQ-027 Minimum latency: accept at cycle N, eng_start at N+1, rsp_valid earliest at N+3 (eng_done at N+2).
REQ-028 A new request SHALL NOT be accepted on the cycle the response completes; the earliest next accept is the following cycle in IDLE.
REQ-029 Outputs other than rsp_valid/req_ready/eng_start/busy SHALL be registered.

Reset
REQ-030 reset=0 SHALL force IDLE, last_grant=1 (requester 0 wins first tie), timer=0, op_count=0, rsp_data=0, rsp_tag=0, rsp_id=0, rsp_error=0, eng_opcode/eng_a/eng_b=0.
REQ-031 During reset, req_ready, eng_start, rsp_valid, busy SHALL be 0.
REQ-032 Reset mid-operation (START/WAIT/RESP) SHALL abort immediately with no response and no op_count change; a late eng_done afterwards is ignored.

Structure
REQ-033 FSM state encoding, AI opcode constants (DOT=000, MATMUL=001, RELU=010, SIGMOID=011, STEP=100), and the requester-id constants SHALL live in a shared package ai_pkg.
REQ-034 The round-robin grant logic SHALL be one sub-module, rr_arbiter2 (inputs valid[1:0], last_grant; output grant one-hot).

Verification
REQ-035 Single req0 (opcode 001, a=3, b=4, tag=5), eng_done 2 cycles after start with result 12 -> rsp_valid with id=0, tag=5, data=12, error=0; op_count=1.
REQ-036 Both requesters valid continuously from reset, 4 ops -> grant order 0,1,0,1.
REQ-037 eng_done never asserted, TIMEOUT_CYCLES=8 -> rsp_valid 8 WAIT cycles after start with data=0, error=1.
REQ-038 rsp_ready held 0 for 5 cycles in RESP -> payload stable, req_ready=0 throughout, single op_count increment on release.
REQ-039 reset=0 asserted during WAIT, then eng_done pulse after reset release -> no response, state IDLE, op_count unchanged.
REQ-040 eng_done coinciding with timer expiry (TIMEOUT_CYCLES=4, done on 4th WAIT cycle) -> error=0, data=eng_result.
